// File: rtl/lcd_write_engine.sv
// lcd_write_engine: accepts {RS, byte} words over a busy/data-ready handshake
// and writes them to an HD44780-style LCD in 8-bit write-only mode, with the
// power-up wait, setup, enable pulse, hold and execution delay the bus needs.
module lcd_write_engine #(
    parameter int unsigned POWERUP_CYCLES    = 750000,
    parameter int unsigned SETUP_CYCLES      = 2,
    parameter int unsigned E_PULSE_CYCLES    = 12,
    parameter int unsigned HOLD_CYCLES       = 2,
    parameter int unsigned EXEC_SHORT_CYCLES = 2000,
    parameter int unsigned EXEC_LONG_CYCLES  = 82000,
    parameter int unsigned CNT_WIDTH         = 20
) (
    input  logic       clock,
    input  logic       internal_reset,
    input  logic       data_ready,
    input  logic [8:0] data_in,
    output logic       lcd_busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    // Terminal counts: a timed state leaves on the edge where count == N-1.
    localparam logic [CNT_WIDTH-1:0] POWERUP_LAST = CNT_WIDTH'(POWERUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETUP_LAST   = CNT_WIDTH'(SETUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] E_LAST       = CNT_WIDTH'(E_PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SHORT_LAST   = CNT_WIDTH'(EXEC_SHORT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LONG_LAST    = CNT_WIDTH'(EXEC_LONG_CYCLES - 1);

    typedef enum logic [2:0] {
        POWERUP,
        IDLE,
        SETUP,
        E_HIGH,
        HOLD,
        EXEC
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] exec_last;
    logic                 is_long;
    logic                 accept;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    assign is_long   = ~lcd_rs && (lcd_data[7:2] == 6'd0) && (lcd_data[1:0] != 2'd0);
    assign exec_last = is_long ? LONG_LAST : SHORT_LAST;
    assign accept    = (state == IDLE) && data_ready;
    assign lcd_rw    = 1'b0;

    // State register; reset restarts the power-up wait from any state.
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            state <= POWERUP;
        end else begin
            state <= state_next;
        end
    end

    // Delay counter: zero on every state entry, held at zero while idle.
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            count <= '0;
        end else if ((state_next != state) || (state == IDLE)) begin
            count <= '0;
        end else begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    // RS and data are captured only on the accept edge and held otherwise.
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else if (accept) begin
            lcd_rs   <= data_in[8];
            lcd_data <= data_in[7:0];
        end
    end

    // Next-state logic plus the state-decoded busy and enable outputs.
    always_comb begin
        state_next = state;
        lcd_busy   = 1'b1;
        lcd_e      = 1'b0;
        case (state)
            POWERUP: begin
                if (count == POWERUP_LAST) state_next = IDLE;
            end
            IDLE: begin
                lcd_busy = 1'b0;
                if (data_ready) state_next = SETUP;
            end
            SETUP: begin
                if (count == SETUP_LAST) state_next = E_HIGH;
            end
            E_HIGH: begin
                lcd_e = 1'b1;
                if (count == E_LAST) state_next = HOLD;
            end
            HOLD: begin
                if (count == HOLD_LAST) state_next = EXEC;
            end
            EXEC: begin
                if (count == exec_last) state_next = IDLE;
            end
            default: begin
                state_next = POWERUP;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: directed checks of the LCD write engine using small
// timing parameters (POWERUP=10, SETUP=2, E=3, HOLD=2, SHORT=5, LONG=20).
module tb_lcd_write_engine;

    logic       clock = 1'b0;
    logic       internal_reset;
    logic       data_ready;
    logic [8:0] data_in;
    logic       lcd_busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;

    int total = 0;
    int bad   = 0;

    lcd_write_engine #(
        .POWERUP_CYCLES   (10),
        .SETUP_CYCLES     (2),
        .E_PULSE_CYCLES   (3),
        .HOLD_CYCLES      (2),
        .EXEC_SHORT_CYCLES(5),
        .EXEC_LONG_CYCLES (20),
        .CNT_WIDTH        (20)
    ) dut (
        .clock         (clock),
        .internal_reset(internal_reset),
        .data_ready    (data_ready),
        .data_in       (data_in),
        .lcd_busy      (lcd_busy),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_e         (lcd_e),
        .lcd_data      (lcd_data)
    );

    // 10 ns clock.
    always #5 clock = ~clock;

    // Advance one edge and settle 1 ns past it before driving or sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Counts busy samples starting at the current sample (power-up wait).
    task automatic measureBusy(output int n);
        n = 0;
        while (lcd_busy && n < 200) begin
            n++;
            step();
        end
    endtask

    // Presents one word, holds data_ready for extra_ready cycles after busy
    // rises (scrambling data_in meanwhile), then follows the write until idle.
    task automatic applyStimulus(input logic [8:0] word, input int extra_ready,
                                 output int busy_len, output int e_first,
                                 output int e_len, output int pulses,
                                 output logic [8:0] seen, output logic rw_seen);
        logic prev_e;
        data_ready = 1'b1;
        data_in    = word;
        step();
        busy_len = 0;
        e_first  = 0;
        e_len    = 0;
        pulses   = 0;
        prev_e   = 1'b0;
        seen     = word;
        rw_seen  = 1'b0;
        while (lcd_busy && busy_len < 200) begin
            busy_len++;
            if ({lcd_rs, lcd_data} !== word) seen = {lcd_rs, lcd_data};
            if (lcd_rw !== 1'b0) rw_seen = 1'b1;
            if (lcd_e) begin
                e_len++;
                if (!prev_e) begin
                    pulses++;
                    if (e_first == 0) e_first = busy_len;
                end
            end
            prev_e = lcd_e;
            if (busy_len > extra_ready) data_ready = 1'b0;
            else data_in = word ^ 9'h1FF;
            step();
        end
        data_ready = 1'b0;
        data_in    = word ^ 9'h0AA;
    endtask

    logic [8:0] stream_words [16] = '{9'h038, 9'h00C, 9'h006, 9'h001,
                                      9'h141, 9'h142, 9'h143, 9'h002,
                                      9'h080, 9'h1C0, 9'h004, 9'h003,
                                      9'h130, 9'h131, 9'h032, 9'h000};
    int         stream_busy  [16] = '{12, 12, 12, 27, 12, 12, 12, 27,
                                      12, 12, 12, 27, 12, 12, 12, 12};

    initial begin
        int         n;
        int         e_first;
        int         e_len;
        int         pulses;
        int         pulse_total;
        logic [8:0] seen;
        logic       rw_seen;
        logic       rw_any;

        // Scenario 1: reset values and the power-up wait.
        internal_reset = 1'b1;
        data_ready     = 1'b0;
        data_in        = 9'h000;
        step();
        step();
        checkOutput("reset_busy", lcd_busy, 1);
        checkOutput("reset_e", lcd_e, 0);
        checkOutput("reset_rs", lcd_rs, 0);
        checkOutput("reset_data", lcd_data, 8'h00);
        checkOutput("reset_rw", lcd_rw, 0);
        internal_reset = 1'b0;
        measureBusy(n);
        checkOutput("powerup_len", n, 10);
        checkOutput("powerup_e", lcd_e, 0);
        checkOutput("powerup_data", lcd_data, 8'h00);

        // Scenario 2: character 'A' with RS=1.
        applyStimulus(9'h141, 0, n, e_first, e_len, pulses, seen, rw_seen);
        checkOutput("char_busy", n, 12);
        checkOutput("char_e_first", e_first, 3);
        checkOutput("char_e_len", e_len, 3);
        checkOutput("char_word", seen, 9'h141);
        checkOutput("char_idle_busy", lcd_busy, 0);

        // Scenario 3: long vs short execution selection.
        applyStimulus(9'h001, 0, n, e_first, e_len, pulses, seen, rw_seen);
        checkOutput("clear_busy", n, 27);
        applyStimulus(9'h038, 0, n, e_first, e_len, pulses, seen, rw_seen);
        checkOutput("func_busy", n, 12);
        applyStimulus(9'h000, 0, n, e_first, e_len, pulses, seen, rw_seen);
        checkOutput("zero_busy", n, 12);
        applyStimulus(9'h002, 0, n, e_first, e_len, pulses, seen, rw_seen);
        checkOutput("home_busy", n, 27);
        applyStimulus(9'h101, 0, n, e_first, e_len, pulses, seen, rw_seen);
        checkOutput("data01_busy", n, 12);
        applyStimulus(9'h004, 0, n, e_first, e_len, pulses, seen, rw_seen);
        checkOutput("entry_busy", n, 12);

        // Scenario 4: data_ready lingers one cycle after busy, data_in moves.
        applyStimulus(9'h148, 1, n, e_first, e_len, pulses, seen, rw_seen);
        checkOutput("linger_pulses", pulses, 1);
        checkOutput("linger_word", seen, 9'h148);
        checkOutput("linger_busy", n, 12);
        step();
        checkOutput("linger_no_reaccept", lcd_busy, 0);
        checkOutput("linger_data_kept", lcd_data, 8'h48);

        // Scenario 5: reset during the enable pulse.
        data_ready = 1'b1;
        data_in    = 9'h141;
        step();
        data_ready = 1'b0;
        step();
        step();
        checkOutput("mid_e_high", lcd_e, 1);
        internal_reset = 1'b1;
        step();
        checkOutput("abort_e", lcd_e, 0);
        checkOutput("abort_busy", lcd_busy, 1);
        checkOutput("abort_data", lcd_data, 8'h00);
        internal_reset = 1'b0;
        data_ready     = 1'b1;
        data_in        = 9'h155;
        measureBusy(n);
        checkOutput("repowerup_len", n, 10);
        step();
        checkOutput("post_pu_accept_busy", lcd_busy, 1);
        checkOutput("post_pu_accept_word", {lcd_rs, lcd_data}, 9'h155);
        data_ready = 1'b0;
        measureBusy(n);
        checkOutput("post_pu_busy", n, 12);

        // Scenario 6: 16 words back to back.
        pulse_total = 0;
        rw_any      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(stream_words[i], 0, n, e_first, e_len, pulses, seen, rw_seen);
            pulse_total += pulses;
            rw_any |= rw_seen;
            checkOutput($sformatf("stream%0d_busy", i), n, stream_busy[i]);
            checkOutput($sformatf("stream%0d_e", i), {e_first[15:0], e_len[15:0]}, {16'd3, 16'd3});
            checkOutput($sformatf("stream%0d_word", i), seen, stream_words[i]);
        end
        checkOutput("stream_pulses", pulse_total, 16);
        checkOutput("stream_rw", rw_any, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
